// File: rtl/alu_arbiter.sv
// alu_arbiter: lets two requesters share one combinational alu, one operation at a time.
//   Requests use a valid/ready handshake. When both requesters are waiting, the one that
//   was not served last wins (round-robin). The winner's operands are registered and drive
//   the alu. The alu outputs are captured one cycle later and returned to that requester
//   over a valid/ready response channel.
// Ports:
//   clk, rst                       clock; synchronous active-high reset
//   req_valid/req_ready [1:0]      per-requester request handshake (ready is one-hot or zero)
//   req_A/req_B [2*DATA_WIDTH]     requester i operands at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ALUop [5:0]                requester i opcode at [i*3 +: 3]
//   rsp_valid/rsp_ready [1:0]      per-requester response handshake (valid is one-hot or zero)
//   rsp_Result, rsp_flags          captured result and {Err, Overflow, CarryOut, Zero}
//   alu_A/alu_B/alu_ALUop          registered operands driven to the alu
//   alu_Result/Overflow/CarryOut/Zero  outputs returned from the alu
module alu_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [2*DATA_WIDTH-1:0] req_A,
  input  logic [2*DATA_WIDTH-1:0] req_B,
  input  logic [5:0]              req_ALUop,
  output logic [1:0]              rsp_valid,
  input  logic [1:0]              rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_Result,
  output logic [3:0]              rsp_flags,
  output logic [DATA_WIDTH-1:0]   alu_A,
  output logic [DATA_WIDTH-1:0]   alu_B,
  output logic [2:0]              alu_ALUop,
  input  logic [DATA_WIDTH-1:0]   alu_Result,
  input  logic                    alu_Overflow,
  input  logic                    alu_CarryOut,
  input  logic                    alu_Zero
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                  state, state_nx;
  logic                    last_grant;
  logic                    owner;
  logic [DATA_WIDTH-1:0]   op_a, op_b;
  logic [2:0]              op_code;
  logic                    grant_idx;
  logic                    accept;
  logic                    rsp_done;
  logic                    illegal;

  // Winner selection: a lone requester wins outright; with both waiting,
  // the one that did not complete the previous operation wins.
  always_comb begin
    grant_idx = 1'b0;
    if (req_valid == 2'b11) grant_idx = ~last_grant;
    else                    grant_idx = req_valid[1];
  end

  assign accept   = (state == IDLE) && (req_valid != 2'b00) && !rst;
  assign rsp_done = (state == RESP) && rsp_ready[owner];
  assign illegal  = (op_code == 3'b011) || (op_code == 3'b100) || (op_code == 3'b101);

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    rsp_valid = '0;
    if (state == RESP) rsp_valid[owner] = 1'b1;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = EXEC;
      EXEC:    state_nx = RESP;
      RESP:    if (rsp_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      op_code    <= '0;
      rsp_Result <= '0;
      rsp_flags  <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        owner   <= grant_idx;
        op_a    <= grant_idx ? req_A[2*DATA_WIDTH-1:DATA_WIDTH] : req_A[DATA_WIDTH-1:0];
        op_b    <= grant_idx ? req_B[2*DATA_WIDTH-1:DATA_WIDTH] : req_B[DATA_WIDTH-1:0];
        op_code <= grant_idx ? req_ALUop[5:3] : req_ALUop[2:0];
      end
      if (state == EXEC) begin
        // Illegal opcodes still complete, but report only the error flag.
        if (illegal) begin
          rsp_Result <= '0;
          rsp_flags  <= 4'b1000;
        end else begin
          rsp_Result <= alu_Result;
          rsp_flags  <= {1'b0, alu_Overflow, alu_CarryOut, alu_Zero};
        end
      end
      if (rsp_done) last_grant <= owner;
    end
  end

  assign alu_A     = op_a;
  assign alu_B     = op_b;
  assign alu_ALUop = op_code;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed scenarios followed by random traffic, checked against a
// behavioural model of the alu and of round-robin service order.
module tb_alu_arbiter;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [2*W-1:0] req_A, req_B;
  logic [5:0]     req_ALUop;
  logic [W-1:0]   rsp_Result, alu_A, alu_B, alu_Result;
  logic [3:0]     rsp_flags;
  logic [2:0]     alu_ALUop;
  logic           alu_Overflow, alu_CarryOut, alu_Zero;

  int n_assert = 0;
  int n_fail   = 0;
  int last_model = 1;

  logic [W-1:0] sA [2];
  logic [W-1:0] sB [2];
  logic [2:0]   sOp[2];

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_A(req_A), .req_B(req_B), .req_ALUop(req_ALUop),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_Result(rsp_Result), .rsp_flags(rsp_flags),
    .alu_A(alu_A), .alu_B(alu_B), .alu_ALUop(alu_ALUop),
    .alu_Result(alu_Result), .alu_Overflow(alu_Overflow),
    .alu_CarryOut(alu_CarryOut), .alu_Zero(alu_Zero)
  );

  typedef struct packed {
    logic [W-1:0] r;
    logic         ovf;
    logic         cout;
    logic         zero;
  } alu_t;

  // Arithmetic model of the shared alu. Illegal opcodes give deliberately noisy
  // outputs so the arbiter's own error response is observable.
  function automatic alu_t alu_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic [2:0] op);
    alu_t o;
    logic [W:0] wide;
    o = '0;
    case (op)
      3'b000: o.r = a & b;
      3'b001: o.r = a | b;
      3'b010: begin
        wide   = {1'b0, a} + {1'b0, b};
        o.r    = wide[W-1:0];
        o.cout = wide[W];
        o.ovf  = (a[W-1] == b[W-1]) && (o.r[W-1] != a[W-1]);
      end
      3'b110: begin
        o.r    = a - b;
        o.cout = (a < b);
        o.ovf  = (a[W-1] != b[W-1]) && (o.r[W-1] != a[W-1]);
      end
      3'b111: o.r = ($signed(a) < $signed(b)) ? 1 : 0;
      default: begin
        o.r    = a ^ b ^ 32'hA5A5_0001;
        o.ovf  = 1'b1;
        o.cout = 1'b1;
      end
    endcase
    o.zero = (o.r == '0);
    return o;
  endfunction

  always_comb begin
    alu_t m;
    m            = alu_model(alu_A, alu_B, alu_ALUop);
    alu_Result   = m.r;
    alu_Overflow = m.ovf;
    alu_CarryOut = m.cout;
    alu_Zero     = m.zero;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2:0] op);
    sA[i] = a; sB[i] = b; sOp[i] = op;
    req_A[i*W +: W]   = a;
    req_B[i*W +: W]   = b;
    req_ALUop[i*3 +: 3] = op;
    req_valid[i] = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    repeat (2) begin
      @(posedge clk); #1;
      check("rst_req_ready", req_ready, 2'b00);
    end
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_alu_op", alu_ALUop, 3'b000);
    check("rst_alu_A", alu_A, 0);
    check("rst_result", rsp_Result, 0);
    check("rst_flags", rsp_flags, 0);
    req_valid = 2'b00;
    rst = 1'b0;
    last_model = 1;
  endtask

  // Serves one operation from IDLE with the current request inputs. Expected winner,
  // result and flags come from the model; stall = response cycles with owner not ready.
  task automatic serve(input int stall, input logic [1:0] noise);
    int w;
    logic [1:0] oh;
    alu_t m;
    logic [W-1:0] er;
    logic [3:0] ef;
    #1;
    w  = (req_valid == 2'b11) ? 1 - last_model : (req_valid[1] ? 1 : 0);
    oh = (w == 1) ? 2'b10 : 2'b01;
    check("grant", req_ready, oh);
    if (sOp[w] inside {3'b011, 3'b100, 3'b101}) begin
      er = '0; ef = 4'b1000;
    end else begin
      m  = alu_model(sA[w], sB[w], sOp[w]);
      er = m.r; ef = {1'b0, m.ovf, m.cout, m.zero};
    end
    @(posedge clk); #1;
    req_valid[w] = 1'b0;
    #1;
    check("exec_rsp_valid", rsp_valid, 2'b00);
    check("exec_req_ready", req_ready, 2'b00);
    @(posedge clk); #1;
    rsp_ready = noise & ~oh;
    #1;
    check("rsp_valid", rsp_valid, oh);
    check("rsp_result", rsp_Result, er);
    check("rsp_flags", rsp_flags, ef);
    check("alu_operands", {alu_A, alu_B}, {sA[w], sB[w]});
    check("alu_op", alu_ALUop, sOp[w]);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #2;
      check("stall_rsp_valid", rsp_valid, oh);
      check("stall_result", {rsp_Result, rsp_flags}, {er, ef});
      check("stall_req_ready", req_ready, 2'b00);
    end
    rsp_ready = oh | noise;
    @(posedge clk); #1;
    rsp_ready = 2'b00;
    #1;
    check("done_rsp_valid", rsp_valid, 2'b00);
    last_model = w;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; rsp_ready = '0;
    req_A = '0; req_B = '0; req_ALUop = '0;

    // 1: reset with both requesting; first grant goes to requester 0
    do_reset();
    // 2: single ADD
    load(0, 5, 7, 3'b010);
    serve(0, 2'b00);
    // 3: contention from a fresh reset, then a third pair alternates back to req0
    do_reset();
    load(0, 9, 9, 3'b110);
    load(1, 3, 5, 3'b111);
    serve(0, 2'b00);
    serve(0, 2'b00);
    load(0, 32'h1234, 32'h00FF, 3'b000);
    load(1, 32'hFFFF_FFFF, 1, 3'b010);
    serve(0, 2'b00);
    serve(0, 2'b00);
    // 4: back-pressure for 4 cycles
    load(1, 32'hF0, 32'h0F, 3'b001);
    serve(4, 2'b00);
    // 5: illegal opcode, then a normal op
    load(0, 1, 1, 3'b100);
    serve(0, 2'b00);
    load(0, 32'hFFFF_0000, 32'h0F0F_0F0F, 3'b000);
    serve(1, 2'b01);
    // 6: signed overflow, then reset during EXEC of the same op
    load(0, 32'h7FFF_FFFF, 1, 3'b010);
    serve(0, 2'b00);
    load(0, 32'h7FFF_FFFF, 1, 3'b010);
    #1;
    check("pre_rst_grant", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    last_model = 1;
    for (int s = 0; s < 3; s++) begin
      @(posedge clk); #1;
      check("dropped_rsp_valid", rsp_valid, 2'b00);
    end
    check("dropped_alu_op", alu_ALUop, 3'b000);
    load(0, 100, 50, 3'b110);
    load(1, 2, 2, 3'b001);
    serve(0, 2'b00);
    serve(0, 2'b00);

    // Random traffic: pending requests are held until served.
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!req_valid[i] && ($urandom_range(0, 1) == 1)) begin
          logic [W-1:0] a, b;
          a = $urandom;
          b = ($urandom_range(0, 3) == 0) ? a : $urandom;
          if ($urandom_range(0, 3) == 0) a = 32'h7FFF_FFFF;
          load(i, a, b, 3'($urandom_range(0, 7)));
        end
      end
      if (req_valid == 2'b00) begin
        int i;
        i = int'($urandom_range(0, 1));
        load(i, $urandom, $urandom, 3'($urandom_range(0, 7)));
      end
      serve(int'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
